// File: rtl/l1_dcache_ctrl.sv
// -----------------------------------------------------------------------------
// l1_dcache_ctrl
//
// Access controller for the single-port, word-wide L1 data cache BRAM. It
// arbitrates between the core load/store port and the refill/debug port and
// issues at most one BRAM operation per cycle. Byte and halfword stores become
// a two-cycle read-modify-write. Loads are size-extracted and sign- or
// zero-extended.
//
// Optional feature macro: DCACHE_RR_ARB_EN
//   defined   -> round-robin arbitration between core and fill on a conflict
//   undefined -> fixed priority, the core always wins
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   c_req/c_we/c_size/c_uns   core request, store flag, access size, unsigned
//   c_addr, c_wd              core byte address, right-aligned store data
//   c_gnt, c_rvalid, c_rdata  core grant, load-valid, extended load data
//   c_err                     one-cycle misalignment pulse
//   f_req/f_we/f_addr/f_wd    refill request, write flag, word address, data
//   f_gnt, f_rvalid, f_rdata  refill grant, read-valid, raw read word
//   mem_a/mem_wd/mem_we       BRAM address, write data, write enable
//   mem_rd                    BRAM read data (registered, valid at T+1)
// -----------------------------------------------------------------------------
module l1_dcache_ctrl #(
   parameter int N  = 1024,
   parameter int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [1:0]    c_size,
   input  logic          c_uns,
   input  logic [31:0]   c_addr,
   input  logic [31:0]   c_wd,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [31:0]   c_rdata,
   output logic          c_err,
   input  logic          f_req,
   input  logic          f_we,
   input  logic [AW-1:0] f_addr,
   input  logic [31:0]   f_wd,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [31:0]   f_rdata,
   output logic [AW-1:0] mem_a,
   output logic [31:0]   mem_wd,
   output logic          mem_we,
   input  logic [31:0]   mem_rd
);

   typedef enum logic {IDLE, RMW} state_t;

   state_t        state;
   logic [AW-1:0] a_q;        // last driven BRAM address, held while idle
   logic [AW-1:0] r_word;     // sub-word store: word address
   logic [31:0]   r_wd;       // sub-word store: right-aligned data
   logic [1:0]    ld_lo;      // byte offset of the last aligned core access
   logic [1:0]    ld_size;    // size of the last aligned core access
   logic          ld_uns;     // zero-extend flag of the last core load
   logic [31:0]   c_hold;     // core rdata held between rvalid pulses
   logic [31:0]   f_hold;     // fill rdata held between rvalid pulses

   logic          c_mis;
   logic          c_sub;
   logic [AW-1:0] c_word;
   logic          sel_core;
   logic          sel_fill;
   logic [31:0]   c_ext;
   logic [31:0]   merged;

   // Extract the addressed byte/half from a word and extend it.
   function automatic logic [31:0] extract(input logic [31:0] w,
                                           input logic [1:0]  lo,
                                           input logic [1:0]  sz,
                                           input logic        uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lo, 3'b000} +: 8];
      h = lo[1] ? w[31:16] : w[15:0];
      case (sz)
         2'b00:   extract = {{24{b[7] & ~uns}}, b};
         2'b01:   extract = {{16{h[15] & ~uns}}, h};
         default: extract = w;
      endcase
   endfunction

   // Replace one byte/half lane of the old word with the new store data.
   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] wd,
                                         input logic [1:0]  lo,
                                         input logic [1:0]  sz);
      logic [31:0] m;
      m = old;
      if (sz == 2'b00) m[{lo, 3'b000} +: 8]         = wd[7:0];
      else             m[{lo[1], 4'b0000} +: 16]    = wd[15:0];
      return m;
   endfunction

   assign c_word = c_addr[AW+1:2];
   assign c_mis  = ((c_size == 2'b01) && c_addr[0]) ||
                   (c_size[1] && (c_addr[1:0] != 2'b00));
   assign c_sub  = ~c_size[1];
   assign c_ext  = extract(mem_rd, ld_lo, ld_size, ld_uns);
   assign merged = merge(mem_rd, r_wd, ld_lo, ld_size);

`ifdef DCACHE_RR_ARB_EN
   logic ptr_fill;            // 1 = fill was granted last

   always_comb begin
      if (c_req && f_req) begin
         sel_core = ptr_fill;
         sel_fill = ~ptr_fill;
      end else begin
         sel_core = c_req;
         sel_fill = f_req;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        ptr_fill <= 1'b1;
      else if (c_gnt) ptr_fill <= 1'b0;
      else if (f_gnt) ptr_fill <= 1'b1;
   end
`else
   assign sel_core = c_req;
   assign sel_fill = f_req & ~c_req;
`endif

   assign c_gnt = (state == IDLE) && sel_core;
   assign f_gnt = (state == IDLE) && sel_fill;

   // Misaligned core grants take the error path and leave the BRAM idle.
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      mem_a  = a_q;
      mem_wd = '0;
      mem_we = 1'b0;
      if (state == RMW) begin
         mem_a  = r_word;
         mem_wd = merged;
         mem_we = 1'b1;
      end else if (c_gnt && !c_mis) begin
         mem_a  = c_word;
         mem_wd = c_wd;
         mem_we = c_we && !c_sub;   // sub-word stores read first
      end else if (f_gnt) begin
         mem_a  = f_addr;
         mem_wd = f_wd;
         mem_we = f_we;
      end
   end

   // Read data is live from the BRAM in the rvalid cycle and held afterwards.
   assign c_rdata = c_rvalid ? c_ext  : c_hold;
   assign f_rdata = f_rvalid ? mem_rd : f_hold;

   // NOTE: sequential state uses non-blocking assignments; reset is async, so
   // asserting rst in RMW drops mem_we immediately and the merge never writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         a_q      <= '0;
         r_word   <= '0;
         r_wd     <= '0;
         ld_lo    <= '0;
         ld_size  <= '0;
         ld_uns   <= 1'b0;
         c_rvalid <= 1'b0;
         f_rvalid <= 1'b0;
         c_err    <= 1'b0;
         c_hold   <= '0;
         f_hold   <= '0;
      end else begin
         a_q      <= mem_a;
         c_rvalid <= c_gnt && !c_mis && !c_we;
         f_rvalid <= f_gnt && !f_we;
         c_err    <= c_gnt && c_mis;
         if (c_rvalid) c_hold <= c_ext;
         if (f_rvalid) f_hold <= mem_rd;
         if (c_gnt && !c_mis) begin
            ld_lo   <= c_addr[1:0];
            ld_size <= c_size;
            ld_uns  <= c_uns;
         end
         case (state)
            IDLE: begin
               if (c_gnt && !c_mis && c_we && c_sub) begin
                  state  <= RMW;
                  r_word <= c_word;
                  r_wd   <= c_wd;
               end
            end
            RMW:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_l1_dcache_ctrl
//
// Directed self-checking bench for l1_dcache_ctrl with a behavioural
// registered-read BRAM. Memory is loaded and inspected only through the fill
// port. Honours DCACHE_RR_ARB_EN for the arbitration expectations.
// -----------------------------------------------------------------------------
module tb_l1_dcache_ctrl;
   localparam int N  = 1024;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          c_req, c_we, c_uns;
   logic [1:0]    c_size;
   logic [31:0]   c_addr, c_wd;
   logic          c_gnt, c_rvalid, c_err;
   logic [31:0]   c_rdata;
   logic          f_req, f_we;
   logic [AW-1:0] f_addr;
   logic [31:0]   f_wd;
   logic          f_gnt, f_rvalid;
   logic [31:0]   f_rdata;
   logic [AW-1:0] mem_a;
   logic [31:0]   mem_wd;
   logic          mem_we;
   logic [31:0]   mem_rd;

   logic [31:0]   mem [0:N-1];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   l1_dcache_ctrl #(.N(N), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_uns(c_uns),
      .c_addr(c_addr), .c_wd(c_wd), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
      .c_rdata(c_rdata), .c_err(c_err),
      .f_req(f_req), .f_we(f_we), .f_addr(f_addr), .f_wd(f_wd),
      .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
   );

   // Single-port BRAM, registered read of the presented address.
   always @(posedge clk) begin
      if (mem_we) mem[mem_a] <= mem_wd;
      mem_rd <= mem[mem_a];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #2;
   endtask

   task automatic core(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
      c_req = 1'b1; c_we = we; c_size = sz; c_uns = uns; c_addr = a; c_wd = wd;
   endtask

   task automatic c_off;
      c_req = 1'b0; c_we = 1'b0; c_size = 2'b10; c_uns = 1'b0; c_addr = '0; c_wd = '0;
   endtask

   task automatic fill(input logic we, input logic [AW-1:0] a, input logic [31:0] wd);
      f_req = 1'b1; f_we = we; f_addr = a; f_wd = wd;
   endtask

   task automatic f_off;
      f_req = 1'b0; f_we = 1'b0; f_addr = '0; f_wd = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      c_off();
      f_off();
      #12;
      check("rst_c_gnt",    {31'd0, c_gnt},    32'd0);
      check("rst_f_gnt",    {31'd0, f_gnt},    32'd0);
      check("rst_c_rvalid", {31'd0, c_rvalid}, 32'd0);
      check("rst_f_rvalid", {31'd0, f_rvalid}, 32'd0);
      check("rst_c_err",    {31'd0, c_err},    32'd0);
      check("rst_mem_we",   {31'd0, mem_we},   32'd0);
      check("rst_c_rdata",  c_rdata,           32'd0);
      check("rst_f_rdata",  f_rdata,           32'd0);
      rst = 1'b0;
      tick();

      // Preload through fill word writes.
      fill(1'b1, 10'd2, 32'hDEADBEEF);
      settle();
      check("fw_f_gnt",  {31'd0, f_gnt},  32'd1);
      check("fw_mem_we", {31'd0, mem_we}, 32'd1);
      check("fw_mem_a",  {22'd0, mem_a},  32'd2);
      check("fw_mem_wd", mem_wd,          32'hDEADBEEF);
      tick();
      fill(1'b1, 10'd1, 32'h11223344);
      tick();
      fill(1'b1, 10'd0, 32'h01020304);
      tick();
      f_off();

      // Word load of 0x8.
      core(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
      settle();
      check("lw_c_gnt",  {31'd0, c_gnt},  32'd1);
      check("lw_mem_we", {31'd0, mem_we}, 32'd0);
      check("lw_mem_a",  {22'd0, mem_a},  32'd2);
      tick();
      c_off();
      check("lw_rvalid", {31'd0, c_rvalid}, 32'd1);
      check("lw_rdata",  c_rdata,           32'hDEADBEEF);
      settle();
      check("idle_mem_we", {31'd0, mem_we}, 32'd0);
      check("idle_mem_a",  {22'd0, mem_a},  32'd2);
      tick();
      check("hold_rvalid", {31'd0, c_rvalid}, 32'd0);
      check("hold_rdata",  c_rdata,           32'hDEADBEEF);

      // sb 0xAA to 0x6, then lb issued straight away (must wait out RMW).
      core(1'b1, 2'b00, 1'b0, 32'h6, 32'hAA);
      settle();
      check("sb_c_gnt",  {31'd0, c_gnt},  32'd1);
      check("sb_mem_we", {31'd0, mem_we}, 32'd0);
      check("sb_mem_a",  {22'd0, mem_a},  32'd1);
      tick();
      core(1'b0, 2'b00, 1'b0, 32'h6, 32'h0);
      settle();
      check("rmw_c_gnt",  {31'd0, c_gnt},  32'd0);
      check("rmw_f_gnt",  {31'd0, f_gnt},  32'd0);
      check("rmw_mem_we", {31'd0, mem_we}, 32'd1);
      check("rmw_mem_a",  {22'd0, mem_a},  32'd1);
      check("rmw_mem_wd", mem_wd,          32'h11AA3344);
      tick();
      settle();
      check("lb_c_gnt", {31'd0, c_gnt}, 32'd1);
      tick();
      check("lb_rvalid", {31'd0, c_rvalid}, 32'd1);
      check("lb_rdata",  c_rdata,           32'hFFFFFFAA);
      core(1'b0, 2'b00, 1'b1, 32'h6, 32'h0);
      tick();
      check("lbu_rdata", c_rdata, 32'h000000AA);
      core(1'b0, 2'b01, 1'b0, 32'hA, 32'h0);
      tick();
      check("lh_rdata", c_rdata, 32'hFFFFDEAD);
      core(1'b0, 2'b01, 1'b1, 32'h4, 32'h0);
      tick();
      check("lhu_rdata", c_rdata, 32'h00003344);

      // Misaligned lh at 0x3 and misaligned sw at 0x5.
      core(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
      settle();
      check("mis_c_gnt",  {31'd0, c_gnt},  32'd1);
      check("mis_mem_we", {31'd0, mem_we}, 32'd0);
      check("mis_mem_a",  {22'd0, mem_a},  32'd1);
      tick();
      c_off();
      check("mis_c_err",  {31'd0, c_err},    32'd1);
      check("mis_rvalid", {31'd0, c_rvalid}, 32'd0);
      core(1'b1, 2'b10, 1'b0, 32'h5, 32'h0);
      settle();
      check("missw_mem_we", {31'd0, mem_we}, 32'd0);
      tick();
      c_off();
      check("missw_c_err", {31'd0, c_err}, 32'd1);
      fill(1'b0, 10'd1, 32'h0);
      settle();
      check("fr_f_gnt", {31'd0, f_gnt}, 32'd1);
      tick();
      f_off();
      check("fr_f_rvalid", {31'd0, f_rvalid}, 32'd1);
      check("fr_f_rdata",  f_rdata,           32'h11AA3344);
      check("fr_c_err",    {31'd0, c_err},    32'd0);

      // Fill write followed by core read of the same word.
      fill(1'b1, 10'd5, 32'h55);
      tick();
      f_off();
      core(1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
      settle();
      check("raw_c_gnt", {31'd0, c_gnt}, 32'd1);
      tick();
      c_off();
      check("raw_rdata", c_rdata, 32'h00000055);

      // sh 0xBEEF to 0x2, reset asserted in the RMW cycle.
      core(1'b1, 2'b01, 1'b0, 32'h2, 32'hBEEF);
      settle();
      check("sh_c_gnt", {31'd0, c_gnt}, 32'd1);
      tick();
      c_off();
      check("shrmw_mem_we", {31'd0, mem_we}, 32'd1);
      rst = 1'b1;
      #1;
      check("abort_mem_we",   {31'd0, mem_we},   32'd0);
      check("abort_c_gnt",    {31'd0, c_gnt},    32'd0);
      check("abort_f_gnt",    {31'd0, f_gnt},    32'd0);
      check("abort_c_rvalid", {31'd0, c_rvalid}, 32'd0);
      check("abort_c_err",    {31'd0, c_err},    32'd0);
      check("abort_c_rdata",  c_rdata,           32'd0);
      check("abort_f_rdata",  f_rdata,           32'd0);
      tick();
      rst = 1'b0;
      tick();
      fill(1'b0, 10'd0, 32'h0);
      tick();
      f_off();
      check("abort_word", f_rdata, 32'h01020304);

      // Arbitration from a fresh pointer: both requesters held for 4 cycles.
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
      core(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
      fill(1'b0, 10'd3, 32'h0);
      for (int i = 0; i < 4; i++) begin
         settle();
`ifdef DCACHE_RR_ARB_EN
         check($sformatf("arb%0d_c_gnt", i), {31'd0, c_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("arb%0d_f_gnt", i), {31'd0, f_gnt}, (i % 2 == 0) ? 32'd0 : 32'd1);
`else
         check($sformatf("arb%0d_c_gnt", i), {31'd0, c_gnt}, 32'd1);
         check($sformatf("arb%0d_f_gnt", i), {31'd0, f_gnt}, 32'd0);
`endif
         tick();
      end
      c_off();
      f_off();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
